memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter XLEN, default 32: address and data width.
REQ-002 Parameter TIMEOUT_CYCLES, default 256: watchdog limit in cycles, used only with ARB_TIMEOUT_EN.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 IReqF  in  1  fetch stage requests an instruction word.
REQ-006 PCF  in  XLEN  fetch address.
REQ-007 FlushF  in  1  discard any fetch currently in flight (taken branch).
REQ-008 InstrF  out  XLEN  fetched instruction, valid when IReadyF=1.
REQ-009 IReadyF  out  1  one-cycle fetch completion strobe.
REQ-010 DReqM  in  1  memory stage load/store request.
REQ-011 DWriteM  in  1  1=store, 0=load.
REQ-012 ALUResultM  in  XLEN  data address.
REQ-013 WriteDataM  in  XLEN  store data.
REQ-014 ByteEnM  in  XLEN/8  store byte enables.
REQ-015 ReadDataM  out  XLEN  load data, valid when DReadyM=1.
REQ-016 DReadyM  out  1  one-cycle data completion strobe.
REQ-017 StallFetch  out  1  stalls fetch until its access completes.
REQ-018 StallMem  out  1  global pipeline stall while the data access is incomplete.
REQ-019 MemReq, MemWe  out  1 each  shared memory port request and write enable.
REQ-020 MemAddr, MemWData  out  XLEN each; MemBe  out  XLEN/8.
REQ-021 MemRData  in  XLEN; MemAck  in  1  memory completion, single cycle.
REQ-022 ErrTimeout  out  1  sticky watchdog error flag.

Function
REQ-023 The arbiter SHALL share one memory port between fetch and data using an FSM with states IDLE, IBUSY and DBUSY.
REQ-024 In IDLE, the arbiter SHALL go to DBUSY if DReqM=1, otherwise to IBUSY if IReqF=1; data has fixed priority.
REQ-025 In IBUSY and DBUSY, MemReq SHALL be 1, and MemAddr/MemWe/MemWData/MemBe SHALL hold values registered at grant time, stable until MemAck.
REQ-026 A granted access SHALL NOT be preempted.
REQ-027 On MemAck in a busy state, the FSM SHALL re-arbitrate in the same cycle per REQ-024 using the next requests, with no idle bubble; the just-completed requester is excluded for that decision.
REQ-028 DReadyM SHALL equal (state==DBUSY & MemAck), and ReadDataM SHALL pass MemRData through.
REQ-029 IReadyF SHALL equal (state==IBUSY & MemAck & !killed), and InstrF SHALL pass MemRData through.
REQ-030 FlushF during IBUSY SHALL set a killed flag, which clears on MemAck; a killed completion produces no IReadyF.
REQ-031 FlushF in the MemAck cycle SHALL suppress IReadyF.
REQ-032 StallMem SHALL equal DReqM & !DReadyM.
REQ-033 StallFetch SHALL equal IReqF & !IReadyF.
REQ-034 Minimum latency SHALL be: request in cycle N, MemReq in cycle N+1, with completion in N+1 if MemAck is immediate.
REQ-035 Outside busy states, MemReq SHALL be 0 and MemWe SHALL be 0.

Reset
REQ-036 Reset SHALL force state IDLE and clear the killed flag, the watchdog counter and ErrTimeout.
REQ-037 After reset, MemReq, MemWe, IReadyF and DReadyM SHALL be 0, and MemAddr/MemWData/MemBe SHALL be 0.
REQ-038 Reset mid-access SHALL abandon the access; a late MemAck in IDLE SHALL be ignored.

Configuration
REQ-039 With ARB_TIMEOUT_EN defined, a counter SHALL count busy cycles without MemAck.
REQ-040 With ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1, the arbiter SHALL force a completion.
REQ-041 A forced data completion SHALL give DReadyM=1 with ReadDataM=0.
REQ-042 A forced fetch completion SHALL give IReadyF=1 (unless killed) with InstrF=32'h00000013 (NOP).
REQ-043 A forced completion SHALL set ErrTimeout and return the FSM to IDLE.
REQ-044 The counter SHALL clear on every grant.
REQ-045 Without ARB_TIMEOUT_EN, busy states SHALL wait indefinitely, and ErrTimeout SHALL be tied to 0.

Verification
REQ-046 Bench: IReqF=1, PCF=0x100, MemAck after 3 cycles with MemRData=0x00500093 -> MemAddr=0x100 held 3 cycles, IReadyF=1 and InstrF=0x00500093 in the ack cycle, StallFetch=0 in that cycle.
REQ-047 Bench: IReqF and DReqM (load, 0x2000) both rise in the same IDLE cycle -> DBUSY first with MemAddr=0x2000; after its ack, IBUSY with no idle cycle.
REQ-048 Bench: store DWriteM=1, addr 0x3004, data 0xDEADBEEF, ByteEnM=4'b0011 -> MemWe=1 and MemBe=4'b0011 until ack; StallMem=1 until the ack cycle.
REQ-049 Bench: FlushF pulse during IBUSY, before ack -> no IReadyF on that ack; the next fetch completes normally.
REQ-050 Bench: reset asserted during DBUSY, then MemAck arrives -> state IDLE, DReadyM stays 0.
REQ-051 Bench (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): load with no MemAck -> DReadyM=1 and ReadDataM=0 at the 8th busy cycle, ErrTimeout=1 and held until reset.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one single-port memory between the instruction fetch stage and the
// data (memory) stage. Data has fixed priority; a granted access runs to
// completion and the arbiter re-arbitrates in the ack cycle with no bubble.
//
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog that forces a
// completion after TIMEOUT_CYCLES busy cycles without MemAck and raises the
// sticky ErrTimeout flag.
//
// Ports
//   clk, reset                  : clock, synchronous active-high reset
//   IReqF, PCF, FlushF          : fetch request, fetch address, fetch kill
//   InstrF, IReadyF, StallFetch : fetch result, completion strobe, stall
//   DReqM, DWriteM, ALUResultM,
//   WriteDataM, ByteEnM         : data request, store flag, addr, data, bytes
//   ReadDataM, DReadyM, StallMem: load result, completion strobe, stall
//   MemReq, MemWe, MemAddr,
//   MemWData, MemBe             : shared memory request port
//   MemRData, MemAck            : memory response
//   ErrTimeout                  : sticky watchdog error
module memory_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IReqF,
  input  logic [XLEN-1:0]   PCF,
  input  logic              FlushF,
  output logic [XLEN-1:0]   InstrF,
  output logic              IReadyF,
  input  logic              DReqM,
  input  logic              DWriteM,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [XLEN/8-1:0] ByteEnM,
  output logic [XLEN-1:0]   ReadDataM,
  output logic              DReadyM,
  output logic              StallFetch,
  output logic              StallMem,
  output logic              MemReq,
  output logic              MemWe,
  output logic [XLEN-1:0]   MemAddr,
  output logic [XLEN-1:0]   MemWData,
  output logic [XLEN/8-1:0] MemBe,
  input  logic [XLEN-1:0]   MemRData,
  input  logic              MemAck,
  output logic              ErrTimeout
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  state_t            state, next_state;
  logic              grant_i, grant_d;
  logic              busy, forced, killed;
  logic              we_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [XLEN/8-1:0] be_q;

  assign busy = (state != IDLE);

  // NOTE: every variable written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (DReqM) begin
          next_state = DBUSY;
          grant_d    = 1'b1;
        end else if (IReqF) begin
          next_state = IBUSY;
          grant_i    = 1'b1;
        end
      end
      // On ack, re-arbitrate among the other requester only; the one that
      // just completed must not be re-granted on a stale request.
      IBUSY: begin
        if (MemAck) begin
          if (DReqM) begin
            next_state = DBUSY;
            grant_d    = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end else if (forced) begin
          next_state = IDLE;
        end
      end
      DBUSY: begin
        if (MemAck) begin
          if (IReqF) begin
            next_state = IBUSY;
            grant_i    = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end else if (forced) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Request fields are captured at grant and held stable until completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= ALUResultM;
      wdata_q <= WriteDataM;
      be_q    <= ByteEnM;
      we_q    <= DWriteM;
    end else if (grant_i) begin
      addr_q  <= PCF;
      wdata_q <= '0;
      be_q    <= '1;
      we_q    <= 1'b0;
    end
  end

  // A flush while a fetch is outstanding poisons that fetch; the flag lives
  // only until the memory answers.
  always_ff @(posedge clk) begin
    if (reset)                                killed <= 1'b0;
    else if (state != IBUSY || MemAck || forced) killed <= 1'b0;
    else if (FlushF)                          killed <= 1'b1;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  logic          err_q;

  // A real ack in the limit cycle wins over the watchdog.
  assign forced = busy && !MemAck && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (grant_i || grant_d)   wd_cnt <= '0;
      else if (busy && !MemAck) wd_cnt <= wd_cnt + 1'b1;
      if (forced)               err_q  <= 1'b1;
    end
  end

  assign ErrTimeout = err_q;
`else
  assign forced     = 1'b0;
  assign ErrTimeout = 1'b0;
`endif

  assign MemReq   = busy;
  assign MemWe    = busy & we_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign MemBe    = be_q;

  assign DReadyM   = (state == DBUSY) & (MemAck | forced);
  assign ReadDataM = forced ? '0 : MemRData;
  assign IReadyF   = (state == IBUSY) & (MemAck | forced) & ~killed & ~FlushF;
  assign InstrF    = forced ? NOP : MemRData;

  assign StallMem   = DReqM & ~DReadyM;
  assign StallFetch = IReqF & ~IReadyF;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed bench for memory_arbiter. The bench plays the memory; expected
// completion data is queued when a request is issued and compared when the
// DUT raises IReadyF / DReadyM.
module tb_memory_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            IReqF, FlushF, DReqM, DWriteM, MemAck;
  logic [31:0]     PCF, ALUResultM, WriteDataM, MemRData;
  logic [3:0]      ByteEnM;
  logic [31:0]     InstrF, ReadDataM, MemAddr, MemWData;
  logic [3:0]      MemBe;
  logic            IReadyF, DReadyM, StallFetch, StallMem, MemReq, MemWe, ErrTimeout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] iq[$];
  logic [31:0] dq[$];

  memory_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .IReqF      (IReqF),
    .PCF        (PCF),
    .FlushF     (FlushF),
    .InstrF     (InstrF),
    .IReadyF    (IReadyF),
    .DReqM      (DReqM),
    .DWriteM    (DWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ByteEnM    (ByteEnM),
    .ReadDataM  (ReadDataM),
    .DReadyM    (DReadyM),
    .StallFetch (StallFetch),
    .StallMem   (StallMem),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemBe      (MemBe),
    .MemRData   (MemRData),
    .MemAck     (MemAck),
    .ErrTimeout (ErrTimeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard: every completion strobe must match a queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (IReadyF === 1'b1) begin
        if (iq.size() == 0) check("spurious_iready", {31'b0, IReadyF}, 32'd0);
        else                check("instr_data", InstrF, iq.pop_front());
      end
      if (DReadyM === 1'b1) begin
        if (dq.size() == 0) check("spurious_dready", {31'b0, DReadyM}, 32'd0);
        else                check("read_data", ReadDataM, dq.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; IReqF = 0; FlushF = 0; DReqM = 0; DWriteM = 0; MemAck = 0;
    PCF = '0; ALUResultM = '0; WriteDataM = '0; MemRData = '0; ByteEnM = '0;
    tick(); tick();
    reset = 1'b0;
    mid();
    check("rst_memreq",  {31'b0, MemReq},  0);
    check("rst_memwe",   {31'b0, MemWe},   0);
    check("rst_iready",  {31'b0, IReadyF}, 0);
    check("rst_dready",  {31'b0, DReadyM}, 0);
    check("rst_addr",    MemAddr,  0);
    check("rst_wdata",   MemWData, 0);
    check("rst_be",      {28'b0, MemBe}, 0);
    check("rst_err",     {31'b0, ErrTimeout}, 0);

    // Fetch with ack in the third busy cycle.
    tick();
    IReqF = 1; PCF = 32'h100;
    iq.push_back(32'h0050_0093);
    mid();
    check("f_idle_memreq", {31'b0, MemReq}, 0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin MemAck = 1; MemRData = 32'h0050_0093; end
      mid();
      check("f_memreq", {31'b0, MemReq}, 1);
      check("f_addr", MemAddr, 32'h100);
      check("f_stall", {31'b0, StallFetch}, (c == 3) ? 32'd0 : 32'd1);
      check("f_iready", {31'b0, IReadyF}, (c == 3) ? 32'd1 : 32'd0);
    end
    tick();
    IReqF = 0; MemAck = 0;
    mid();
    check("f_done_memreq", {31'b0, MemReq}, 0);

    // Simultaneous fetch and load: data first, then fetch without a bubble.
    tick();
    IReqF = 1; PCF = 32'h200; DReqM = 1; DWriteM = 0; ALUResultM = 32'h2000;
    dq.push_back(32'hCAFE_0001);
    iq.push_back(32'h1111_1111);
    mid();
    check("p_stallmem", {31'b0, StallMem}, 1);
    tick();
    MemAck = 1; MemRData = 32'hCAFE_0001;
    mid();
    check("p_d_addr", MemAddr, 32'h2000);
    check("p_d_we", {31'b0, MemWe}, 0);
    check("p_d_dready", {31'b0, DReadyM}, 1);
    check("p_d_stallmem", {31'b0, StallMem}, 0);
    tick();
    DReqM = 0; MemRData = 32'h1111_1111;
    mid();
    check("p_i_memreq", {31'b0, MemReq}, 1);
    check("p_i_addr", MemAddr, 32'h200);
    check("p_i_iready", {31'b0, IReadyF}, 1);
    tick();
    IReqF = 0; MemAck = 0;
    mid();
    check("p_idle", {31'b0, MemReq}, 0);

    // Store held until ack on the third busy cycle.
    tick();
    DReqM = 1; DWriteM = 1; ALUResultM = 32'h3004; WriteDataM = 32'hDEAD_BEEF; ByteEnM = 4'b0011;
    MemRData = 32'h0;
    dq.push_back(32'h0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) MemAck = 1;
      mid();
      check("s_we", {31'b0, MemWe}, 1);
      check("s_be", {28'b0, MemBe}, 32'h3);
      check("s_addr", MemAddr, 32'h3004);
      check("s_wdata", MemWData, 32'hDEAD_BEEF);
      check("s_stallmem", {31'b0, StallMem}, (c == 3) ? 32'd0 : 32'd1);
    end
    tick();
    DReqM = 0; DWriteM = 0; MemAck = 0;
    mid();
    check("s_after_we", {31'b0, MemWe}, 0);

    // Flushed fetch produces no IReadyF; the following fetch completes.
    tick();
    IReqF = 1; PCF = 32'h300;
    tick();
    FlushF = 1;
    mid();
    check("k_memreq", {31'b0, MemReq}, 1);
    tick();
    FlushF = 0; PCF = 32'h400; MemAck = 1; MemRData = 32'h0BAD_0BAD;
    mid();
    check("k_iready", {31'b0, IReadyF}, 0);
    check("k_stall", {31'b0, StallFetch}, 1);
    tick();
    MemAck = 0;
    iq.push_back(32'h1234_5678);
    mid();
    check("k_idle", {31'b0, MemReq}, 0);
    tick();
    MemAck = 1; MemRData = 32'h1234_5678;
    mid();
    check("k2_addr", MemAddr, 32'h400);
    check("k2_iready", {31'b0, IReadyF}, 1);
    tick();
    IReqF = 0; MemAck = 0;

    // Reset during a data access; a late ack must be ignored.
    tick();
    DReqM = 1; ALUResultM = 32'h5000;
    tick();
    mid();
    check("r_busy", {31'b0, MemReq}, 1);
    tick();
    reset = 1;
    tick();
    reset = 0; DReqM = 0; MemAck = 1; MemRData = 32'h5555_5555;
    mid();
    check("r_dready", {31'b0, DReadyM}, 0);
    check("r_memreq", {31'b0, MemReq}, 0);
    check("r_addr", MemAddr, 0);
    tick();
    MemAck = 0;

`ifdef ARB_TIMEOUT_EN
    // Load that is never acknowledged: forced completion at busy cycle 8.
    tick();
    DReqM = 1; ALUResultM = 32'h6000; MemRData = 32'hFFFF_FFFF;
    dq.push_back(32'h0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      mid();
      check("t_dready", {31'b0, DReadyM}, (c == 8) ? 32'd1 : 32'd0);
      check("t_err_pre", {31'b0, ErrTimeout}, 0);
    end
    tick();
    DReqM = 0;
    mid();
    check("t_idle", {31'b0, MemReq}, 0);
    check("t_err", {31'b0, ErrTimeout}, 1);
    tick(); tick();
    mid();
    check("t_err_hold", {31'b0, ErrTimeout}, 1);
    tick();
    reset = 1;
    tick();
    reset = 0;
    mid();
    check("t_err_clr", {31'b0, ErrTimeout}, 0);
`else
    mid();
    check("err_tied", {31'b0, ErrTimeout}, 0);
`endif

    tick();
    mid();
    check("iq_empty", iq.size(), 0);
    check("dq_empty", dq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
